// File: rtl/dram_pkg.sv
// ---------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the DRAM controller: the command encoding driven by
// the command FSM, and the default JEDEC timing parameters (in clock cycles)
// that both the command FSM and the timing controller are elaborated with.
// No ports.
// ---------------------------------------------------------------------------
package dram_pkg;

    // Command issued by the command FSM in a given cycle
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_t;

    // Default timing parameters, all in clock cycles
    localparam int T_RCD   = 4;    // ACT to RD/WR
    localparam int T_CL    = 5;    // RD to first data beat
    localparam int T_CWL   = 4;    // WR to first data beat
    localparam int T_BURST = 4;    // data beats per burst
    localparam int T_WR    = 3;    // write recovery after last beat
    localparam int T_RP    = 4;    // precharge period
    localparam int T_RFC   = 20;   // refresh cycle time
    localparam int T_REFI  = 100;  // refresh interval

    // Larger of two integers, usable in constant expressions
    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_timing_if.sv
// ---------------------------------------------------------------------------
// dram_timing_if
// Timing-signal bundle between the command FSM and the timing controller.
//   tACT_done/tRD_done/tWR_done/tPRE_done/tREF_done : command timing complete
//   rf_req : refresh is due
//   wr_en / rd_en : write / read data window
//   clear  : resets downstream burst counters, coincident with any *_done
// ---------------------------------------------------------------------------
interface dram_timing_if;

    logic tACT_done;
    logic tWR_done;
    logic tRD_done;
    logic tPRE_done;
    logic tREF_done;
    logic rf_req;
    logic wr_en;
    logic rd_en;
    logic clear;

    modport timing_ctrl (
        output tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
        output rf_req, wr_en, rd_en, clear
    );

    modport cmd_fsm (
        input tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
        input rf_req, wr_en, rd_en, clear
    );

endinterface

// File: rtl/refresh_timer.sv
// ---------------------------------------------------------------------------
// refresh_timer
// Free-running tREFI interval counter with the rf_req handshake. One instance
// serves one rank.
// Ports:
//   i_clk       : clock
//   i_nRst      : synchronous active-low reset
//   i_refAccept : a REF command is being accepted this cycle
//   o_rfReq     : refresh due; held until a REF is accepted
// ---------------------------------------------------------------------------
module refresh_timer
    import dram_pkg::*;
#(
    parameter int tREFI = T_REFI
) (
    input  logic i_clk,
    input  logic i_nRst,
    input  logic i_refAccept,
    output logic o_rfReq
);

    localparam int CNT_W = (tREFI > 1) ? $clog2(tREFI) : 1;
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(tREFI - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nextCount;
    logic             r_rfReq;

    // A REF accept always restarts the interval, even in the very cycle the
    // threshold would be reached; otherwise count up and park at the
    // threshold while the request is outstanding.
    always_comb begin
        w_nextCount = r_count;
        if (i_refAccept) begin
            w_nextCount = '0;
        end else if (r_count != THRESH) begin
            w_nextCount = r_count + CNT_W'(1);
        end
    end

    // The request is registered from the next count so it rises in the same
    // cycle the counter shows the threshold.
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_count <= '0;
            r_rfReq <= 1'b0;
        end else begin
            r_count <= w_nextCount;
            r_rfReq <= !i_refAccept && (w_nextCount == THRESH);
        end
    end

    assign o_rfReq = r_rfReq;

endmodule

// File: rtl/dram_timing_ctrl.sv
// ---------------------------------------------------------------------------
// dram_timing_ctrl
// Times each DRAM command accepted from the command FSM against its timing
// parameter, pulses the matching *_done (with clear), generates the read and
// write data windows, and hosts the refresh interval timer.
// Ports:
//   CLK   : clock
//   nRST  : synchronous active-low reset
//   cmd_i : command issued this cycle (only acted on while idle)
//   tsif  : timing_ctrl side of the timing-signal interface (all registered)
// ---------------------------------------------------------------------------
module dram_timing_ctrl
    import dram_pkg::*;
#(
    parameter int tRCD   = T_RCD,
    parameter int tCL    = T_CL,
    parameter int tCWL   = T_CWL,
    parameter int tBURST = T_BURST,
    parameter int tWR    = T_WR,
    parameter int tRP    = T_RP,
    parameter int tRFC   = T_RFC,
    parameter int tREFI  = T_REFI
) (
    input  logic  CLK,
    input  logic  nRST,
    input  cmd_t  cmd_i,
    dram_timing_if.timing_ctrl tsif
);

    if (tRCD < 1 || tCL < 1 || tCWL < 1 || tBURST < 1 ||
        tWR < 1 || tRP < 1 || tRFC < 1 || tREFI < 1) begin : g_badParams
        $error("dram_timing_ctrl: timing parameters must all be at least 1");
    end

    // tREFI is counted by the refresh timer, so it does not size this counter
    localparam int MAX_T = maxOf(maxOf(maxOf(tRCD, tCL), maxOf(tCWL, tBURST)),
                                 maxOf(maxOf(tWR, tRP), tRFC));
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ACT_WAIT = 4'd1;
    localparam logic [3:0] ST_RD_LAT   = 4'd2;
    localparam logic [3:0] ST_RD_BURST = 4'd3;
    localparam logic [3:0] ST_WR_LAT   = 4'd4;
    localparam logic [3:0] ST_WR_BURST = 4'd5;
    localparam logic [3:0] ST_WR_RECOV = 4'd6;
    localparam logic [3:0] ST_PRE_WAIT = 4'd7;
    localparam logic [3:0] ST_REF_WAIT = 4'd8;

    // Counter load values: a state lasts (load + 1) cycles and leaves when the
    // counter reads zero. RD_BURST and WR_RECOV carry one extra cycle so their
    // final (done) cycle follows the last beat / the recovery time.
    localparam logic [CNT_W-1:0] LD_ACT    = CNT_W'(tRCD - 1);
    localparam logic [CNT_W-1:0] LD_RD_LAT = CNT_W'((tCL > 1) ? tCL - 2 : 0);
    localparam logic [CNT_W-1:0] LD_RD_BUR = CNT_W'(tBURST);
    localparam logic [CNT_W-1:0] LD_WR_LAT = CNT_W'((tCWL > 1) ? tCWL - 2 : 0);
    localparam logic [CNT_W-1:0] LD_WR_BUR = CNT_W'(tBURST - 1);
    localparam logic [CNT_W-1:0] LD_RECOV  = CNT_W'(tWR);
    localparam logic [CNT_W-1:0] LD_PRE    = CNT_W'(tRP - 1);
    localparam logic [CNT_W-1:0] LD_REF    = CNT_W'(tRFC - 1);

    logic [3:0]       r_state;
    logic [3:0]       w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;

    logic w_lastCycle;
    logic w_actDone, w_rdDone, w_wrDone, w_preDone, w_refDone;
    logic w_rdEn, w_wrEn;
    logic w_refAccept;
    logic w_rfReq;

    logic r_actDone, r_rdDone, r_wrDone, r_preDone, r_refDone;
    logic r_rdEn, r_wrEn, r_clear;

    // Next-state and shared countdown. Commands are looked at only in IDLE;
    // a one-cycle latency phase (tCL/tCWL of 1) skips straight to the burst.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        if (r_state == ST_IDLE) begin
            case (cmd_i)
                CMD_ACT: begin
                    w_nextState = ST_ACT_WAIT;
                    w_nextCnt   = LD_ACT;
                end
                CMD_RD: begin
                    if (tCL > 1) begin
                        w_nextState = ST_RD_LAT;
                        w_nextCnt   = LD_RD_LAT;
                    end else begin
                        w_nextState = ST_RD_BURST;
                        w_nextCnt   = LD_RD_BUR;
                    end
                end
                CMD_WR: begin
                    if (tCWL > 1) begin
                        w_nextState = ST_WR_LAT;
                        w_nextCnt   = LD_WR_LAT;
                    end else begin
                        w_nextState = ST_WR_BURST;
                        w_nextCnt   = LD_WR_BUR;
                    end
                end
                CMD_PRE: begin
                    w_nextState = ST_PRE_WAIT;
                    w_nextCnt   = LD_PRE;
                end
                CMD_REF: begin
                    w_nextState = ST_REF_WAIT;
                    w_nextCnt   = LD_REF;
                end
                default: ;
            endcase
        end else if (r_cnt != '0) begin
            w_nextCnt = r_cnt - CNT_W'(1);
        end else begin
            w_nextState = ST_IDLE;
            w_nextCnt   = '0;
            case (r_state)
                ST_RD_LAT: begin
                    w_nextState = ST_RD_BURST;
                    w_nextCnt   = LD_RD_BUR;
                end
                ST_WR_LAT: begin
                    w_nextState = ST_WR_BURST;
                    w_nextCnt   = LD_WR_BUR;
                end
                ST_WR_BURST: begin
                    w_nextState = ST_WR_RECOV;
                    w_nextCnt   = LD_RECOV;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so that, once registered, they
    // line up with the state they describe without any path from cmd_i.
    always_comb begin
        w_lastCycle = (w_nextCnt == '0);
        w_actDone   = (w_nextState == ST_ACT_WAIT) && w_lastCycle;
        w_rdDone    = (w_nextState == ST_RD_BURST) && w_lastCycle;
        w_wrDone    = (w_nextState == ST_WR_RECOV) && w_lastCycle;
        w_preDone   = (w_nextState == ST_PRE_WAIT) && w_lastCycle;
        w_refDone   = (w_nextState == ST_REF_WAIT) && w_lastCycle;
        w_rdEn      = (w_nextState == ST_RD_BURST) && !w_lastCycle;
        w_wrEn      = (w_nextState == ST_WR_BURST);
        w_refAccept = (r_state == ST_IDLE) && (cmd_i == CMD_REF);
    end

    // State, countdown and registered outputs; reset drops everything at once
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_actDone <= 1'b0;
            r_rdDone  <= 1'b0;
            r_wrDone  <= 1'b0;
            r_preDone <= 1'b0;
            r_refDone <= 1'b0;
            r_rdEn    <= 1'b0;
            r_wrEn    <= 1'b0;
            r_clear   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_actDone <= w_actDone;
            r_rdDone  <= w_rdDone;
            r_wrDone  <= w_wrDone;
            r_preDone <= w_preDone;
            r_refDone <= w_refDone;
            r_rdEn    <= w_rdEn;
            r_wrEn    <= w_wrEn;
            r_clear   <= w_actDone | w_rdDone | w_wrDone | w_preDone | w_refDone;
        end
    end

    refresh_timer #(
        .tREFI (tREFI)
    ) u_refreshTimer (
        .i_clk       (CLK),
        .i_nRst      (nRST),
        .i_refAccept (w_refAccept),
        .o_rfReq     (w_rfReq)
    );

    assign tsif.tACT_done = r_actDone;
    assign tsif.tRD_done  = r_rdDone;
    assign tsif.tWR_done  = r_wrDone;
    assign tsif.tPRE_done = r_preDone;
    assign tsif.tREF_done = r_refDone;
    assign tsif.rd_en     = r_rdEn;
    assign tsif.wr_en     = r_wrEn;
    assign tsif.clear     = r_clear;
    assign tsif.rf_req    = w_rfReq;

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dram_timing_ctrl
// Directed bench for dram_timing_ctrl with default timing parameters.
// Cycle 0 is the first cycle after the last clock edge that sampled nRST low;
// a command driven in cycle N is accepted at the edge ending cycle N.
// Outputs are packed as {tACT,tWR,tRD,tPRE,tREF,rf_req,wr_en,rd_en,clear}.
// ---------------------------------------------------------------------------
module tb_dram_timing_ctrl;
    import dram_pkg::*;

    localparam logic [8:0] V_ACT = 9'b1_0000_0000;
    localparam logic [8:0] V_WR  = 9'b0_1000_0000;
    localparam logic [8:0] V_RD  = 9'b0_0100_0000;
    localparam logic [8:0] V_PRE = 9'b0_0010_0000;
    localparam logic [8:0] V_REF = 9'b0_0001_0000;
    localparam logic [8:0] V_RFQ = 9'b0_0000_1000;
    localparam logic [8:0] V_WEN = 9'b0_0000_0100;
    localparam logic [8:0] V_REN = 9'b0_0000_0010;
    localparam logic [8:0] V_CLR = 9'b0_0000_0001;

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    cmd_t cmd  = CMD_NOP;
    int   cyc  = 0;
    int   errors = 0;
    int   checks = 0;

    dram_timing_if tsif ();

    dram_timing_ctrl dut (
        .CLK   (clk),
        .nRST  (nRST),
        .cmd_i (cmd),
        .tsif  (tsif)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle number relative to the last reset
    always @(posedge clk) begin
        if (!nRST) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Safety net in case the clock or a wait loop misbehaves
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [8:0] outVec();
        return {tsif.tACT_done, tsif.tWR_done, tsif.tRD_done, tsif.tPRE_done,
                tsif.tREF_done, tsif.rf_req, tsif.wr_en, tsif.rd_en, tsif.clear};
    endfunction

    // Reset for a few cycles; returns at the falling edge of cycle 0
    task automatic doReset();
        cmd  = CMD_NOP;
        nRST = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
    endtask

    // Advance to the falling edge of cycle n, with a bounded wait
    task automatic stepTo(input int n);
        int guard = 0;
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("[TB] FAIL stepTo cycle got=%0d want=%0d", cyc, n);
        end
    endtask

    task automatic test_reset();
        logic [8:0] got;
        nRST = 1'b0;
        cmd  = CMD_ACT;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = outVec();
            checks++;
            if (got !== 9'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold i=%0d got=%b want=%b", i, got, 9'b0);
            end
        end
        cmd  = CMD_NOP;
        nRST = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            stepTo(c);
            got = outVec();
            checks++;
            if (got !== 9'b0) begin
                errors++;
                $display("[TB] FAIL reset_after c=%0d got=%b want=%b", c, got, 9'b0);
            end
        end
    endtask

    task automatic test_act_rd_wr();
        logic [8:0] got, exp;
        doReset();
        for (int c = 9; c <= 53; c++) begin
            stepTo(c);
            got = outVec();
            exp = '0;
            if (c == 14) exp = V_ACT | V_CLR;
            if (c >= 25 && c <= 28) exp = V_REN;
            if (c == 29) exp = V_RD | V_CLR;
            if (c >= 44 && c <= 47) exp = V_WEN;
            if (c == 51) exp = V_WR | V_CLR;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL act_rd_wr c=%0d got=%b want=%b", c, got, exp);
            end
            cmd = (c == 10) ? CMD_ACT : (c == 20) ? CMD_RD : (c == 40) ? CMD_WR : CMD_NOP;
        end
        cmd = CMD_NOP;
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp;
        doReset();
        for (int c = 9; c <= 38; c++) begin
            stepTo(c);
            got = outVec();
            exp = '0;
            if (c == 14) exp = V_ACT | V_CLR;
            if (c >= 20 && c <= 23) exp = V_REN;
            if (c == 24) exp = V_RD | V_CLR;
            if (c >= 29 && c <= 32) exp = V_WEN;
            if (c == 36) exp = V_WR | V_CLR;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL back_to_back c=%0d got=%b want=%b", c, got, exp);
            end
            cmd = (c == 10) ? CMD_ACT : (c == 15) ? CMD_RD : (c == 25) ? CMD_WR : CMD_NOP;
        end
        cmd = CMD_NOP;
    endtask

    task automatic test_ignore_busy();
        logic [8:0] got, exp;
        doReset();
        for (int c = 18; c <= 37; c++) begin
            stepTo(c);
            got = outVec();
            exp = '0;
            if (c >= 25 && c <= 28) exp = V_REN;
            if (c == 29) exp = V_RD | V_CLR;
            if (c == 34) exp = V_PRE | V_CLR;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL ignore_busy c=%0d got=%b want=%b", c, got, exp);
            end
            cmd = (c == 20) ? CMD_RD :
                  (c == 22 || c == 29 || c == 30) ? CMD_PRE : CMD_NOP;
        end
        cmd = CMD_NOP;
    endtask

    task automatic test_refresh();
        logic [8:0] got, exp;
        doReset();
        for (int c = 96; c <= 130; c++) begin
            stepTo(c);
            got = outVec();
            exp = '0;
            if (c >= 99 && c <= 105) exp = V_RFQ;
            if (c == 125) exp = V_REF | V_CLR;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL refresh c=%0d got=%b want=%b", c, got, exp);
            end
            cmd = (c == 105) ? CMD_REF : CMD_NOP;
        end
        for (int c = 202; c <= 207; c++) begin
            stepTo(c);
            got = outVec();
            exp = (c >= 205) ? V_RFQ : 9'b0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL refresh_next c=%0d got=%b want=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_ref_wins();
        logic [8:0] got, exp;
        doReset();
        for (int c = 96; c <= 120; c++) begin
            stepTo(c);
            got = outVec();
            exp = (c == 118) ? (V_REF | V_CLR) : 9'b0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL ref_wins c=%0d got=%b want=%b", c, got, exp);
            end
            cmd = (c == 98) ? CMD_REF : CMD_NOP;
        end
        cmd = CMD_NOP;
    endtask

    task automatic test_reset_midop();
        logic [8:0] got, exp;
        doReset();
        for (int c = 39; c <= 45; c++) begin
            stepTo(c);
            got = outVec();
            exp = (c >= 44) ? V_WEN : 9'b0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL midop_pre c=%0d got=%b want=%b", c, got, exp);
            end
            cmd = (c == 40) ? CMD_WR : CMD_NOP;
        end
        nRST = 1'b0;
        @(negedge clk);
        got = outVec();
        checks++;
        if (got !== 9'b0) begin
            errors++;
            $display("[TB] FAIL midop_abort got=%b want=%b", got, 9'b0);
        end
        nRST = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            stepTo(c);
            got = outVec();
            exp = (c == 9) ? (V_ACT | V_CLR) : 9'b0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL midop_after c=%0d got=%b want=%b", c, got, exp);
            end
            cmd = (c == 5) ? CMD_ACT : CMD_NOP;
        end
        cmd = CMD_NOP;
    endtask

    initial begin
        $display("[TB] dram_timing_ctrl bench start");
        test_reset();
        test_act_rd_wr();
        test_back_to_back();
        test_ignore_busy();
        test_refresh();
        test_ref_wins();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_timing_ctrl.md
# dram_timing_ctrl

Timing-control end of the DRAM controller's timing-signal interface: drives the `timing_ctrl` side that the command FSM consumes. It times each issued DRAM command against its JEDEC parameter and pulses the matching `*_done`. It also generates the read/write data-window enables and a periodic refresh request. It sits beside the command FSM, between the FSM and the data path.

## Interface
Parameters (cycles):
- tRCD, 4: ACT-to-RD/WR delay
- tCL, 5: RD-to-first-data latency
- tCWL, 4: WR-to-first-data latency
- tBURST, 4: data beats per burst
- tWR, 3: write recovery after last beat
- tRP, 4: precharge period
- tRFC, 20: refresh cycle time
- tREFI, 100: refresh interval

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; one clock, synchronous, active-low
- cmd_i  in  cmd_t (3)  command issued this cycle: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5
- tsif  modport `timing_ctrl`  —  drives tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, rf_req, wr_en, rd_en, clear (all 1 bit)

## Operation
- FSM states: IDLE, ACT_WAIT, RD_LAT, RD_BURST, WR_LAT, WR_BURST, WR_RECOV, PRE_WAIT, REF_WAIT.
- One down-counter is shared by all states and loaded on each state entry.
- Commands are accepted only in IDLE. A non-NOP `cmd_i` in any other state is ignored: no state or counter change.
- Let N be the accept cycle.
- ACT: tACT_done pulses at N+tRCD.
- RD: rd_en is high for cycles N+tCL … N+tCL+tBURST-1. tRD_done pulses at N+tCL+tBURST.
- WR: wr_en is high for cycles N+tCWL … N+tCWL+tBURST-1. tWR_done pulses at N+tCWL+tBURST+tWR.
- PRE: tPRE_done pulses at N+tRP.
- REF: tREF_done pulses at N+tRFC.
- The done-pulse cycle is the last cycle of the wait state. The FSM is in IDLE the following cycle.
- A command presented in the done-pulse cycle is ignored. The command FSM issues its next command one cycle after the done pulse.
- clear: single-cycle pulse coincident with every `*_done` pulse, so downstream burst counters reset.
- Refresh counter:
  - Free-running up-counter, independent of the FSM; width $clog2(tREFI).
  - When it reaches tREFI-1, rf_req sets and stays high until a REF is accepted. The counter holds at tREFI-1 while rf_req is high.
  - On REF accept, the counter goes to 0 and rf_req clears the next cycle.
  - If REF is accepted in the same cycle the threshold is reached, REF wins: the counter restarts at 0 and rf_req never asserts.
- rf_req does not block other commands. Honouring it is the command FSM's job.
- Counter width: $clog2(max(all cycle params)+1). Parameters of 0 are illegal; an elaboration-time assertion checks for this.

## Timing
- Reset values: all tsif outputs 0, state IDLE, both counters 0.
- Reset mid-operation aborts any burst or wait immediately: no done pulse, and enables drop the cycle after nRST is sampled low.
- All outputs are registered. No combinational path from cmd_i to any output.
- At most one `*_done` is high in any cycle.
- rd_en and wr_en are never high together.

## Structure
- `cmd_t` enum belongs in `dram_pkg`.
- The default timing-parameter localparams (tRCD … tREFI) also belong in `dram_pkg`, shared with the command FSM.
- The FSM state enum is local to the module.
- One natural sub-module: `refresh_timer` (tREFI counter + rf_req handshake), reusable per rank.
- Top module: the FSM plus the shared countdown.

## Test plan
- Reset, then ACT at cycle 10 -> tACT_done and clear high only at cycle 14; all else 0.
- RD at cycle 20 -> rd_en high cycles 25–28; tRD_done at 29; wr_en stays 0.
- WR at cycle 40 -> wr_en high cycles 44–47; tWR_done at 51.
- RD accepted at 20, then PRE presented at 22 and at 29 -> both ignored; PRE at 30 gives tPRE_done at 34.
- Idle from reset -> rf_req rises at cycle 99 and holds. REF at 105 -> rf_req low at 106, tREF_done at 125, next rf_req at 205.
- nRST low at the 2nd cycle of wr_en -> wr_en 0 next cycle; no tWR_done; rf_req 0; a following ACT times normally.
